// File: rtl/dm_result_checker.sv
// dm_result_checker: snoops the CPU DM for the end signature, then scans the result
// words through a secondary read port and compares them against a loaded golden table.
module dm_result_checker #(
    parameter int                ADDR_W       = 14,
    parameter int                NUM_MAX      = 64,
    parameter logic [ADDR_W-1:0] SIM_END_ADDR = 14'h3fff,
    parameter logic [ADDR_W-1:0] TEST_START   = 14'h2000,
    parameter logic [31:0]       END_CODE     = 32'hFFFF_FFFF,
    parameter int                MAX_CYCLES   = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_dm_we,
    input  logic [3:0]        i_dm_be,
    input  logic [ADDR_W-1:0] i_dm_addr,
    input  logic [31:0]       i_dm_wdata,
    input  logic              i_gold_we,
    input  logic [5:0]        i_gold_idx,
    input  logic [31:0]       i_gold_data,
    input  logic [6:0]        i_num,
    output logic              o_chk_req,
    input  logic              i_chk_gnt,
    output logic [ADDR_W-1:0] o_chk_addr,
    input  logic [31:0]       i_chk_rdata,
    output logic              o_done,
    output logic              o_pass,
    output logic              o_timeout,
    output logic [6:0]        o_err_count,
    output logic [6:0]        o_first_err_idx,
    output logic [63:0]       o_cycle_count
);
    typedef enum logic [2:0] {IDLE, REQ, SCAN, DRAIN, DONE} state_t;

    state_t      r_state, w_next;
    logic [6:0]  r_n, r_idx, r_err, r_first;
    logic [5:0]  r_cidx;
    logic        r_vld, r_timeout;
    logic [63:0] r_cycles;
    logic [31:0] r_gold [NUM_MAX];
    logic        w_sig, w_tmo, w_last, w_mis;
    logic [6:0]  w_num_c;

    assign w_num_c = (i_num > 7'(NUM_MAX)) ? 7'(NUM_MAX) : i_num;
    assign w_sig   = i_dm_we && i_dm_be == 4'hF && i_dm_addr == SIM_END_ADDR && i_dm_wdata == END_CODE;
    assign w_tmo   = r_cycles == 64'(MAX_CYCLES - 1);
    assign w_last  = r_idx == r_n - 7'd1;
    // r_vld marks that the previous cycle issued a granted address, so rdata is live now
    assign w_mis   = r_vld && (i_chk_rdata != r_gold[r_cidx]);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_sig ? REQ : (w_tmo ? DONE : IDLE);
            REQ:     w_next = !i_chk_gnt ? REQ : (r_n == 7'd0 ? DRAIN : SCAN);
            SCAN:    w_next = (i_chk_gnt && w_last) ? DRAIN : SCAN;
            default: w_next = DONE;
        endcase
    end

    assign o_chk_req       = r_state == REQ || r_state == SCAN;
    assign o_chk_addr      = r_state == SCAN ? TEST_START + ADDR_W'(r_idx) : '0;
    assign o_done          = r_state == DONE;
    assign o_pass          = o_done && !r_timeout && r_err == 7'd0;
    assign o_timeout       = r_timeout;
    assign o_err_count     = r_err;
    assign o_first_err_idx = r_first;
    assign o_cycle_count   = r_cycles;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_n       <= '0;
            r_idx     <= '0;
            r_cidx    <= '0;
            r_vld     <= 1'b0;
            r_err     <= '0;
            r_first   <= 7'h7F;
            r_timeout <= 1'b0;
            r_cycles  <= '0;
        end else begin
            r_state <= w_next;
            r_vld   <= r_state == SCAN && i_chk_gnt;
            r_cidx  <= r_idx[5:0];
            if (r_state == IDLE) begin
                r_n   <= w_num_c;
                r_idx <= '0;
                if (!w_sig && !w_tmo)
                    r_cycles <= r_cycles + 64'd1;
                if (!w_sig && w_tmo) begin
                    r_timeout <= 1'b1;
                    r_err     <= w_num_c;
                    r_first   <= w_num_c == 7'd0 ? 7'h7F : 7'd0;
                end
            end
            if (r_state == SCAN && i_chk_gnt)
                r_idx <= r_idx + 7'd1;
            if (w_mis) begin
                r_err <= r_err + 7'd1;
                if (r_err == 7'd0)
                    r_first <= {1'b0, r_cidx};
            end
        end
    end

    // golden table is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (r_state == IDLE && i_gold_we)
            r_gold[i_gold_idx] <= i_gold_data;
    end
endmodule

// File: tb/tb_dm_result_checker.sv
// tb_dm_result_checker: directed scenarios; a schedule-level model predicts the
// signature cycle, issue cycles, done cycle and final verdict for per-cycle checking.
module tb_dm_result_checker;
    localparam int MAXC = 50;

    logic        clk, rst;
    logic        i_dm_we, i_gold_we, i_chk_gnt;
    logic [3:0]  i_dm_be;
    logic [13:0] i_dm_addr;
    logic [31:0] i_dm_wdata, i_gold_data, i_chk_rdata;
    logic [5:0]  i_gold_idx;
    logic [6:0]  i_num;
    logic        o_chk_req, o_done, o_pass, o_timeout;
    logic [13:0] o_chk_addr;
    logic [6:0]  o_err_count, o_first_err_idx;
    logic [63:0] o_cycle_count;

    dm_result_checker #(.MAX_CYCLES(MAXC)) dut (
        .clk(clk), .rst(rst),
        .i_dm_we(i_dm_we), .i_dm_be(i_dm_be), .i_dm_addr(i_dm_addr), .i_dm_wdata(i_dm_wdata),
        .i_gold_we(i_gold_we), .i_gold_idx(i_gold_idx), .i_gold_data(i_gold_data),
        .i_num(i_num), .o_chk_req(o_chk_req), .i_chk_gnt(i_chk_gnt), .o_chk_addr(o_chk_addr),
        .i_chk_rdata(i_chk_rdata), .o_done(o_done), .o_pass(o_pass), .o_timeout(o_timeout),
        .o_err_count(o_err_count), .o_first_err_idx(o_first_err_idx), .o_cycle_count(o_cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk or posedge rst)
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;

    logic        we_s [128];
    logic [3:0]  be_s [128];
    logic [13:0] ad_s [128];
    logic [31:0] wd_s [128];
    logic        gnt_s [128];
    logic [31:0] gold_v [64];
    logic [31:0] dm_res [64];
    int          iss [128];
    int          ngold, late_k;
    logic [6:0]  num_v;

    int          exp_t, exp_done, exp_last, done_at;
    logic        exp_tmo, exp_pass;
    logic [6:0]  exp_err, exp_first;
    logic        chk_on, cap_iss;
    logic [13:0] cap_addr;
    int          checks, errors;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] dm_at(input logic [13:0] a);
        logic [13:0] o;
        o = a - 14'h2000;
        return o < 14'd64 ? dm_res[o[5:0]] : 32'h0;
    endfunction

    task automatic clear_tables;
        for (int i = 0; i < 128; i++) begin
            we_s[i] = 1'b0; be_s[i] = 4'h0; ad_s[i] = '0; wd_s[i] = '0; gnt_s[i] = 1'b1;
        end
        for (int i = 0; i < 64; i++) begin
            gold_v[i] = 32'(i + 1);
            dm_res[i] = 32'(i + 1);
        end
        ngold = 4; late_k = -1; num_v = 7'd4;
    endtask

    task automatic set_wr(input int c, input logic [3:0] be, input logic [13:0] a, input logic [31:0] d);
        we_s[c] = 1'b1; be_s[c] = be; ad_s[c] = a; wd_s[c] = d;
    endtask

    // model: derive the whole expected run from the stimulus schedule
    task automatic plan;
        int c, j, n;
        n = num_v > 7'd64 ? 64 : int'(num_v);
        for (int i = 0; i < 128; i++) iss[i] = -1;
        exp_t = -1;
        for (int i = 0; i < MAXC; i++)
            if (exp_t < 0 && we_s[i] && be_s[i] == 4'hF && ad_s[i] == 14'h3fff && wd_s[i] == 32'hFFFF_FFFF)
                exp_t = i;
        exp_err = 7'd0; exp_first = 7'h7F;
        if (exp_t < 0) begin
            exp_tmo = 1'b1; exp_t = MAXC - 1; exp_done = MAXC; exp_last = -1;
            exp_err = 7'(n); exp_first = n == 0 ? 7'h7F : 7'h0; exp_pass = 1'b0;
        end else begin
            exp_tmo = 1'b0;
            c = exp_t + 1;
            while (c < 120 && !gnt_s[c]) c++;
            exp_last = c; j = 0;
            while (j < n && c < 120) begin
                c++;
                if (gnt_s[c]) begin iss[c] = j; j++; exp_last = c; end
            end
            exp_done = exp_last + 2;
            for (int i = 0; i < n; i++)
                if (dm_res[i] != gold_v[i]) begin
                    if (exp_err == 7'd0) exp_first = 7'(i);
                    exp_err++;
                end
            exp_pass = exp_err == 7'd0;
        end
    endtask

    task automatic drive(input int k);
        i_dm_we = we_s[k]; i_dm_be = be_s[k]; i_dm_addr = ad_s[k]; i_dm_wdata = wd_s[k];
        i_chk_gnt = gnt_s[k]; i_num = num_v;
        i_gold_we = (k < ngold) || (k == late_k);
        i_gold_idx = (k == late_k) ? 6'd1 : 6'(k);
        i_gold_data = (k == late_k) ? 32'hDEAD_BEEF : gold_v[6'(k)];
        i_chk_rdata = cap_iss ? dm_at(cap_addr) : 32'hBAD0_BAD0;
    endtask

    task automatic do_reset;
        chk_on = 1'b0; cap_iss = 1'b0; cap_addr = '0;
        i_dm_we = 0; i_dm_be = 0; i_dm_addr = 0; i_dm_wdata = 0; i_gold_we = 0;
        i_gold_idx = 0; i_gold_data = 0; i_num = 0; i_chk_gnt = 0; i_chk_rdata = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic run(input int ncyc);
        chk_on = 1'b1;
        for (int k = 0; k < ncyc; k++) begin
            drive(k);
            @(negedge clk);
            cap_iss = iss[k] >= 0;
            cap_addr = o_chk_addr;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic lit(input logic [6:0] e_err, input logic [6:0] e_first, input logic e_pass,
                       input logic e_tmo, input int e_done, input int e_cc);
        chk("lit_done_cycle", 64'(done_at), 64'(e_done));
        chk("lit_err_count", 64'(o_err_count), 64'(e_err));
        chk("lit_first_err", 64'(o_first_err_idx), 64'(e_first));
        chk("lit_pass", 64'(o_pass), 64'(e_pass));
        chk("lit_timeout", 64'(o_timeout), 64'(e_tmo));
        chk("lit_cycle_count", o_cycle_count, 64'(e_cc));
    endtask

    always @(negedge clk) begin
        int k;
        if (!chk_on || rst) done_at = -1;
        else begin
            k = cyc;
            if (o_done && done_at < 0) done_at = k;
            chk("done", 64'(o_done), 64'(k >= exp_done));
            chk("cycle_count", o_cycle_count, 64'(k <= exp_t ? k : exp_t));
            chk("chk_req", 64'(o_chk_req), 64'(!exp_tmo && k > exp_t && k <= exp_last));
            if (k < 128 && iss[k] >= 0)
                chk("chk_addr", 64'(o_chk_addr), 64'(14'h2000 + 14'(iss[k])));
            if (k >= exp_done) begin
                chk("pass", 64'(o_pass), 64'(exp_pass));
                chk("err_count", 64'(o_err_count), 64'(exp_err));
                chk("first_err_idx", 64'(o_first_err_idx), 64'(exp_first));
                chk("timeout", 64'(o_timeout), 64'(exp_tmo));
            end else begin
                chk("pass_early", 64'(o_pass), 64'd0);
                chk("timeout_early", 64'(o_timeout), 64'd0);
            end
        end
    end

    initial begin
        checks = 0; errors = 0; chk_on = 1'b0; done_at = -1;
        // all-match run; a golden write after the signature must be ignored
        clear_tables; set_wr(6, 4'hF, 14'h3fff, 32'hFFFF_FFFF); late_k = 8;
        plan; do_reset; run(exp_done + 3);
        lit(7'd0, 7'h7F, 1'b1, 1'b0, 13, 6);
        // single mismatch at index 2
        clear_tables; set_wr(6, 4'hF, 14'h3fff, 32'hFFFF_FFFF); dm_res[2] = 32'd5;
        plan; do_reset; run(exp_done + 3);
        lit(7'd1, 7'd2, 1'b0, 1'b0, 13, 6);
        // near-miss signatures do not trigger
        clear_tables;
        set_wr(4, 4'h7, 14'h3fff, 32'hFFFF_FFFF);
        set_wr(5, 4'hF, 14'h3ffe, 32'hFFFF_FFFF);
        set_wr(6, 4'hF, 14'h3fff, 32'hFFFF_FFFE);
        set_wr(8, 4'hF, 14'h3fff, 32'hFFFF_FFFF);
        plan; do_reset; run(exp_done + 3);
        lit(7'd0, 7'h7F, 1'b1, 1'b0, 15, 8);
        // late grant plus a two-cycle grant drop mid-scan
        clear_tables; set_wr(6, 4'hF, 14'h3fff, 32'hFFFF_FFFF);
        gnt_s[7] = 0; gnt_s[8] = 0; gnt_s[9] = 0; gnt_s[13] = 0; gnt_s[14] = 0;
        plan; do_reset; run(exp_done + 3);
        lit(7'd0, 7'h7F, 1'b1, 1'b0, 18, 6);
        // timeout with num=4, num=100 (clamped), num=0
        clear_tables;
        plan; do_reset; run(exp_done + 3);
        lit(7'd4, 7'd0, 1'b0, 1'b1, 50, 49);
        clear_tables; num_v = 7'd100;
        plan; do_reset; run(exp_done + 3);
        lit(7'd64, 7'd0, 1'b0, 1'b1, 50, 49);
        clear_tables; num_v = 7'd0;
        plan; do_reset; run(exp_done + 3);
        lit(7'd0, 7'h7F, 1'b0, 1'b1, 50, 49);
        // num=0 with signature
        clear_tables; num_v = 7'd0; set_wr(5, 4'hF, 14'h3fff, 32'hFFFF_FFFF);
        plan; do_reset; run(exp_done + 3);
        lit(7'd0, 7'h7F, 1'b1, 1'b0, 8, 5);
        // signature on the timeout cycle wins
        clear_tables; num_v = 7'd0; set_wr(49, 4'hF, 14'h3fff, 32'hFFFF_FFFF);
        plan; do_reset; run(exp_done + 3);
        lit(7'd0, 7'h7F, 1'b1, 1'b0, 52, 49);
        // asynchronous reset in the middle of a scan
        clear_tables; set_wr(6, 4'hF, 14'h3fff, 32'hFFFF_FFFF); dm_res[0] = 32'd9;
        plan; do_reset; run(11);
        chk_on = 1'b0;
        chk("pre_rst_req", 64'(o_chk_req), 64'd1);
        chk("pre_rst_err", 64'(o_err_count), 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("rst_chk_req", 64'(o_chk_req), 64'd0);
        chk("rst_chk_addr", 64'(o_chk_addr), 64'd0);
        chk("rst_done", 64'(o_done), 64'd0);
        chk("rst_pass", 64'(o_pass), 64'd0);
        chk("rst_timeout", 64'(o_timeout), 64'd0);
        chk("rst_err_count", 64'(o_err_count), 64'd0);
        chk("rst_first_err", 64'(o_first_err_idx), 64'h7F);
        chk("rst_cycle_count", o_cycle_count, 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dm_result_checker.md
# dm_result_checker

Synthesizable end-of-test checker for the CPU `top` data memory. It snoops CPU-side DM writes and detects the end-of-simulation signature: a full-word write of END_CODE to SIM_END_ADDR. It then takes a secondary SRAM read port and scans NUM result words starting at TEST_START. Each word is compared against a locally loaded golden table, and the block reports pass/fail, error count, first failing index and the cycle count at termination. It is the hardware reader of the results the CPU writes, usable on FPGA/emulation where no testbench backdoor exists.

## Interface
- ADDR_W, 14, DM word-address width (16384 words)
- NUM_MAX, 64, golden table depth
- SIM_END_ADDR, 14'h3fff, end-signature word address
- TEST_START, 14'h2000, first result word address
- END_CODE, 32'hFFFF_FFFF, end signature value
- MAX_CYCLES, 100000, timeout in cycles after reset

- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- dm_we  in  1  CPU DM write strobe (snooped)
- dm_be  in  4  CPU DM byte enables, active-high
- dm_addr  in  ADDR_W  CPU DM word address
- dm_wdata  in  32  CPU DM write data
- gold_we  in  1  golden table write strobe
- gold_idx  in  6  golden table index
- gold_data  in  32  golden word
- num  in  7  number of result words to check; values > NUM_MAX are clamped to NUM_MAX
- chk_req  out  1  request for DM read port
- chk_gnt  in  1  read port granted
- chk_addr  out  ADDR_W  read address
- chk_rdata  in  32  read data, valid exactly 1 cycle after address
- done  out  1  check finished (sticky until reset)
- pass  out  1  valid when done: no errors and no timeout
- timeout  out  1  MAX_CYCLES reached before signature
- err_count  out  7  mismatching words
- first_err_idx  out  7  index of first mismatch; 7'h7F if none
- cycle_count  out  64  cycles from reset release, frozen at signature detect or timeout

## Operation
- FSM states: IDLE, REQ, SCAN, DRAIN, DONE.
- IDLE
  - cycle_count increments each cycle.
  - gold_we writes golden[gold_idx]. gold_we is ignored outside IDLE.
  - Transition to REQ when dm_we && dm_be==4'hF && dm_addr==SIM_END_ADDR && dm_wdata==END_CODE.
  - Partial-byte writes never trigger.
  - Signature and timeout in the same cycle: signature wins.
- Timeout: in IDLE with cycle_count==MAX_CYCLES-1 → DONE with timeout=1, err_count=clamped num, pass=0, first_err_idx=0 (or 7'h7F if num==0).
- REQ
  - chk_req=1; stay in REQ until chk_gnt.
  - On grant with clamped num==0 → DONE, pass=1.
  - Otherwise → SCAN with idx=0.
- SCAN
  - chk_req held at 1; chk_addr=TEST_START+idx; idx increments each cycle.
  - Compare is pipelined: chk_rdata in cycle t is compared with golden[idx issued at t-1].
  - After the last address is issued → DRAIN.
  - If chk_gnt drops mid-scan: hold the address, do not advance idx, discard the compare the following cycle, resume when the grant returns.
- DRAIN: final compare → DONE.
- Compare (`!==`-equivalent, full 32 bits):
  - On mismatch, err_count += 1.
  - On the first mismatch, first_err_idx = index.
- DONE: chk_req=0; outputs frozen; only rst exits.
- Address arithmetic wraps modulo 2^ADDR_W.

## Timing
- Reset values: chk_req=0, chk_addr=0, done=0, pass=0, timeout=0, err_count=0, first_err_idx=7'h7F, cycle_count=0, state IDLE. Golden table contents are not reset.
- Signature write in cycle t: cycle_count frozen at its value in cycle t; REQ (chk_req=1) from cycle t+1.
- With continuous grant arriving in cycle g: addresses issued g+1 .. g+N, done=1 in cycle g+N+2.
- Reset mid-scan: all outputs return to reset values asynchronously; scan is abandoned.
- Snoop inputs are ignored in every state except IDLE.

## Test plan
- Load golden[0..3]=1,2,3,4, num=4; DM at 0x2000..0x2003 holds 1,2,3,4; full-word write of FFFFFFFF to 0x3fff; chk_gnt tied 1 → done at detect+1+4+2 cycles, pass=1, err_count=0, first_err_idx=7F.
- Same setup, DM[0x2002]=5 → pass=0, err_count=1, first_err_idx=2.
- Signature written with dm_be=4'h7, then with dm_wdata=FFFFFFFE → no trigger; a later correct write triggers.
- chk_gnt low for 3 cycles after REQ and dropped for 2 cycles mid-scan → addresses 0x2000..0x2003 each compared exactly once, result identical to the first scenario.
- MAX_CYCLES=50, no signature, num=4 → done at cycle 50, timeout=1, err_count=4, pass=0.
- num=0 with signature → done 2 cycles after grant, pass=1. Asserting rst during SCAN → all outputs at reset values immediately.
